// File: rtl/sd_cic3_decim_if.sv
// Bitstream-in / decimated-word-out bundle for sd_cic3_decim.
// master = bitstream source / sample consumer, slave = the decimator.
interface sd_cic3_decim_if #(
  parameter int OW    = 12,
  parameter int LOG2R = 6
);
  logic                   bs_in;
  logic                   bs_valid;
  logic                   sync;
  logic signed [OW-1:0]   dout;
  logic                   dout_valid;
  logic [LOG2R-1:0]       phase;

  modport master (
    output bs_in, bs_valid, sync,
    input  dout, dout_valid, phase
  );

  modport slave (
    input  bs_in, bs_valid, sync,
    output dout, dout_valid, phase
  );
endinterface

// File: rtl/sd_cic3_decim.sv
// Third-order CIC (sinc^3) decimator for a 1-bit sigma-delta bitstream, R = 2^LOG2R.
// Define SD_CIC3_DECIM_SAT_EN to clamp the scaled output instead of wrapping it.
module sd_cic3_decim #(
  parameter int OW    = 12,
  parameter int LOG2R = 6
) (
  input  logic             clk,
  input  logic             reset,
  sd_cic3_decim_if.slave   bus
);

  localparam int ACCW = 3*LOG2R + 2;
  localparam int SH   = 3*LOG2R - OW + 1;

`ifdef SD_CIC3_DECIM_SAT_EN
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((1 << (OW-1)) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;
`endif

  logic signed [ACCW-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic signed [ACCW-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic signed [ACCW-1:0] c3_q, c3_d;
  logic [LOG2R-1:0]       phase_q, phase_d;
  logic                   dec_tick_q, dec_tick_d;
  logic                   out_pend_q, out_pend_d;
  logic signed [OW-1:0]   dout_q, dout_d;
  logic                   dout_valid_q, dout_valid_d;

  logic signed [ACCW-1:0] x;
  logic signed [ACCW-1:0] c1, c2, c3;
  logic signed [ACCW-1:0] shifted;
  logic                   comb_en;

  always_comb begin
    i1_d         = i1_q;
    i2_d         = i2_q;
    i3_d         = i3_q;
    d1_d         = d1_q;
    d2_d         = d2_q;
    d3_d         = d3_q;
    c3_d         = c3_q;
    phase_d      = phase_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;

    x = bus.bs_in ? ACCW'(1) : '1;

    if (bus.bs_valid) begin
      i1_d    = i1_q + x;
      i2_d    = i2_q + i1_q;
      i3_d    = i3_q + i2_q;
      phase_d = phase_q + LOG2R'(1);
    end
    if (bus.sync) begin
      phase_d = '0;
    end

    dec_tick_d = bus.bs_valid && (phase_q == '1) && !bus.sync;

    // sync on the tick cycle cancels the comb update; history is left untouched
    comb_en    = dec_tick_q && !bus.sync;
    c1         = i3_q - d1_q;
    c2         = c1 - d2_q;
    c3         = c2 - d3_q;
    out_pend_d = comb_en;
    if (comb_en) begin
      d1_d = i3_q;
      d2_d = c1;
      d3_d = c2;
      c3_d = c3;
    end

    shifted = c3_q >>> SH;
    if (out_pend_q) begin
      dout_valid_d = 1'b1;
`ifdef SD_CIC3_DECIM_SAT_EN
      if (shifted > SAT_MAX) begin
        dout_d = OW'(SAT_MAX);
      end else if (shifted < SAT_MIN) begin
        dout_d = OW'(SAT_MIN);
      end else begin
        dout_d = OW'(shifted);
      end
`else
      dout_d = OW'(shifted);
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i1_q         <= '0;
      i2_q         <= '0;
      i3_q         <= '0;
      d1_q         <= '0;
      d2_q         <= '0;
      d3_q         <= '0;
      c3_q         <= '0;
      phase_q      <= '0;
      dec_tick_q   <= 1'b0;
      out_pend_q   <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      i1_q         <= i1_d;
      i2_q         <= i2_d;
      i3_q         <= i3_d;
      d1_q         <= d1_d;
      d2_q         <= d2_d;
      d3_q         <= d3_d;
      c3_q         <= c3_d;
      phase_q      <= phase_d;
      dec_tick_q   <= dec_tick_d;
      out_pend_q   <= out_pend_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.phase      = phase_q;

endmodule

// File: tb/tb_sd_cic3_decim.sv
// Directed-vector bench for sd_cic3_decim (default OW=12, LOG2R=6).
module tb_sd_cic3_decim;
  localparam int OW    = 12;
  localparam int LOG2R = 6;
`ifdef SD_CIC3_DECIM_SAT_EN
  localparam int EXP_FS = 2047;
`else
  localparam int EXP_FS = -2048;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sd_cic3_decim_if #(.OW(OW), .LOG2R(LOG2R)) bus ();

  sd_cic3_decim #(.OW(OW), .LOG2R(LOG2R)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic signed [OW-1:0] cap_val [8];
  int                   cap_cyc [8];
  int                   cap_n;

  task automatic step(input logic vld, input logic bit_in);
    bus.bs_valid = vld;
    bus.bs_in    = bit_in;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    bus.bs_valid = 1'b0;
    bus.bs_in    = 1'b0;
    bus.sync     = 1'b0;
    reset        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // mode 0 ones, 1 zeros, 2 alternating, 3 three-of-four ones, 4 valid toggling with ones
  task automatic run_pattern(input int mode, input int nstr);
    int   nb;
    logic v, b;
    nb    = 0;
    cap_n = 0;
    for (int cyc = 0; cyc < 2000 && cap_n < nstr; cyc++) begin
      v = 1'b1;
      case (mode)
        0:       b = 1'b1;
        1:       b = 1'b0;
        2:       b = (nb % 2 == 0);
        3:       b = (nb % 4 != 3);
        default: begin v = (cyc % 2 == 0); b = 1'b1; end
      endcase
      step(v, b);
      if (v) nb++;
      if (bus.dout_valid === 1'b1) begin
        cap_val[cap_n] = bus.dout;
        cap_cyc[cap_n] = cyc;
        cap_n++;
      end
    end
    bus.bs_valid = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (bus.dout !== '0) begin errors++; $display("FAIL reset_dout: got %0d want 0", bus.dout); end
    checks++;
    if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.dout_valid); end
    checks++;
    if (bus.phase !== '0) begin errors++; $display("FAIL reset_phase: got %0d want 0", bus.phase); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic check_steady(input string name, input int expv, input int first_cyc, input int period);
    checks++;
    if (cap_n !== 6) begin errors++; $display("FAIL %s_count: got %0d strobes want 6", name, cap_n); end
    checks++;
    if (cap_n > 0 && cap_cyc[0] !== first_cyc) begin
      errors++; $display("FAIL %s_latency: got cycle %0d want %0d", name, cap_cyc[0], first_cyc);
    end
    for (int i = 1; i < cap_n; i++) begin
      checks++;
      if (cap_cyc[i] - cap_cyc[i-1] !== period) begin
        errors++; $display("FAIL %s_period[%0d]: got %0d want %0d", name, i, cap_cyc[i] - cap_cyc[i-1], period);
      end
    end
    for (int i = 3; i < cap_n; i++) begin
      checks++;
      if (int'(cap_val[i]) !== expv) begin
        errors++; $display("FAIL %s_value[%0d]: got %0d want %0d", name, i, cap_val[i], expv);
      end
    end
  endtask

  task automatic test_all_ones;
    for (int k = 0; k < 20; k++) step(1'b1, 1'b1);
    checks++;
    if (bus.phase !== 6'd20) begin errors++; $display("FAIL pre_reset_phase: got %0d want 20", bus.phase); end
    do_reset();
    checks++;
    if (bus.phase !== '0) begin errors++; $display("FAIL midrun_reset_phase: got %0d want 0", bus.phase); end
    run_pattern(0, 6);
    check_steady("ones", EXP_FS, 65, 64);
  endtask

  task automatic test_all_zeros;
    do_reset();
    run_pattern(1, 6);
    check_steady("zeros", -2048, 65, 64);
  endtask

  task automatic test_alternating;
    do_reset();
    run_pattern(2, 6);
    check_steady("alt", 0, 65, 64);
  endtask

  task automatic test_three_quarter;
    do_reset();
    run_pattern(3, 6);
    check_steady("q3", 1024, 65, 64);
  endtask

  task automatic test_valid_gap;
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    checks++;
    if (bus.phase !== 6'd3) begin errors++; $display("FAIL gap_phase_hold: got %0d want 3", bus.phase); end
    step(1'b0, 1'b0);
    checks++;
    if (bus.phase !== 6'd3) begin errors++; $display("FAIL gap_phase_hold2: got %0d want 3", bus.phase); end
    do_reset();
    run_pattern(4, 6);
    check_steady("gap", EXP_FS, 128, 128);
  endtask

  task automatic test_sync;
    int seen;
    do_reset();
    for (int k = 0; k < 30; k++) step(1'b1, 1'b1);
    checks++;
    if (bus.phase !== 6'd30) begin errors++; $display("FAIL sync_pre_phase: got %0d want 30", bus.phase); end
    bus.sync = 1'b1;
    step(1'b1, 1'b1);
    bus.sync = 1'b0;
    checks++;
    if (bus.phase !== '0) begin errors++; $display("FAIL sync_phase: got %0d want 0", bus.phase); end
    seen = 0;
    for (int k = 0; k < 65; k++) begin
      step(1'b1, 1'b1);
      if (bus.dout_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL sync_quiet: got %0d strobes want 0", seen); end
    checks++;
    if (bus.phase !== 6'd1) begin errors++; $display("FAIL sync_phase_after: got %0d want 1", bus.phase); end
    step(1'b1, 1'b1);
    checks++;
    if (bus.dout_valid !== 1'b1) begin errors++; $display("FAIL sync_strobe: got %b want 1", bus.dout_valid); end
    bus.bs_valid = 1'b0;
  endtask

  task automatic test_reset_mid_tick;
    int seen;
    do_reset();
    run_pattern(0, 4);
    checks++;
    if (int'(bus.dout) !== EXP_FS) begin errors++; $display("FAIL tick_pre_dout: got %0d want %0d", bus.dout, EXP_FS); end
    for (int k = 0; k < 64 && bus.phase !== 6'd63; k++) step(1'b1, 1'b1);
    checks++;
    if (bus.phase !== 6'd63) begin errors++; $display("FAIL tick_phase: got %0d want 63", bus.phase); end
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    checks++;
    if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL tick_early: got %b want 0", bus.dout_valid); end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.dout !== '0) begin errors++; $display("FAIL tick_rst_dout: got %0d want 0", bus.dout); end
    checks++;
    if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL tick_rst_valid: got %b want 0", bus.dout_valid); end
    checks++;
    if (bus.phase !== '0) begin errors++; $display("FAIL tick_rst_phase: got %0d want 0", bus.phase); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0);
      if (bus.dout_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL tick_no_strobe: got %0d strobes want 0", seen); end
  endtask

  initial begin
    reset        = 1'b0;
    bus.bs_in    = 1'b0;
    bus.bs_valid = 1'b0;
    bus.sync     = 1'b0;
    #2;
    test_reset();
    test_all_ones();
    test_all_zeros();
    test_alternating();
    test_three_quarter();
    test_valid_gap();
    test_sync();
    test_reset_mid_tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
